// File: rtl/rgb_matrix_pwm.sv
// RGB LED matrix driver for 74HC595 chains: Wishbone framebuffer, BPC-bit PWM across frames.
// Optional macro SEPARATE_COLOR_EN drives one colour per frame, rotating R->B->G.
module rgb_matrix_pwm #(
  parameter int ROWS          = 8,
  parameter int COLS          = 8,
  parameter int BPC           = 4,
  parameter int WB_DATA_WIDTH = 32,
  parameter int DIV_WIDTH     = 16,
  parameter int DIV_RESET     = 7,
  parameter int PAUSE_CYCLES  = 32,
  localparam int AW           = $clog2(ROWS * COLS) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_wb_cyc,
  input  logic                       i_wb_stb,
  input  logic                       i_wb_we,
  input  logic [AW-1:0]              i_wb_addr,
  input  logic [WB_DATA_WIDTH/8-1:0] i_wb_sel,
  input  logic [WB_DATA_WIDTH-1:0]   i_wb_wdata,
  output logic                       o_wb_ack,
  output logic                       o_wb_stall,
  output logic [WB_DATA_WIDTH-1:0]   o_wb_rdata,
  output logic                       o_matrix_clk,
  output logic                       o_matrix_latch,
  output logic                       o_matrix_mosi,
  output logic                       o_frame_start
);

  localparam int NPIX    = ROWS * COLS;
  localparam int PAW     = AW - 1;
  localparam int PXW     = 3 * BPC;
  localparam int CHAIN   = 3 * COLS + ROWS;
  localparam int CW      = $clog2(CHAIN + PAUSE_CYCLES + 1);
  localparam int RW      = $clog2(ROWS);
  localparam int SW      = WB_DATA_WIDTH / 8;
  localparam int PWM_MAX = (1 << BPC) - 2;

  typedef enum logic [2:0] {
    S_INIT, S_SHIFT_COLOR, S_SHIFT_ANODE, S_LATCH, S_PAUSE, S_IDLE
  } state_t;

  function automatic logic [WB_DATA_WIDTH-1:0] merge(input logic [WB_DATA_WIDTH-1:0] old,
                                                     input logic [WB_DATA_WIDTH-1:0] wd,
                                                     input logic [SW-1:0]            sel);
    logic [WB_DATA_WIDTH-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++)
      if (sel[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [BPC-1:0] pwm_step(input logic [BPC-1:0] p);
    return (p == BPC'(PWM_MAX)) ? '0 : p + BPC'(1);
  endfunction

  // ---------------- Wishbone register file ----------------
  logic [PXW-1:0]           fb [NPIX];
  logic                     en;
  logic [DIV_WIDTH-1:0]     div_reg;
  logic                     acc, is_ctrl, pix_ok;
  logic [PAW-1:0]           loc;
  logic [PXW-1:0]           fb_rd;
  logic [WB_DATA_WIDTH-1:0] m_pix, m_ctrl, m_div, rd_val, status;
  logic                     unused_bits;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [1:0]     grp, grp_n;
  logic [RW-1:0]  row, row_n;
  logic [BPC-1:0] pwm, pwm_n;
  logic           blank, blank_n;

  assign acc         = i_wb_cyc & i_wb_stb;
  assign is_ctrl     = i_wb_addr[AW-1];
  assign loc         = i_wb_addr[PAW-1:0];
  assign pix_ok      = int'(loc) < NPIX;
  assign fb_rd       = pix_ok ? fb[loc] : '0;
  assign m_pix       = merge(WB_DATA_WIDTH'(fb_rd), i_wb_wdata, i_wb_sel);
  assign m_ctrl      = merge(WB_DATA_WIDTH'(en), i_wb_wdata, i_wb_sel);
  assign m_div       = merge(WB_DATA_WIDTH'(div_reg), i_wb_wdata, i_wb_sel);
  assign unused_bits = ^{m_pix, m_ctrl, m_div};
  assign o_wb_stall  = 1'b0;

  always_comb begin
    status       = '0;
    status[15:8] = 8'(pwm);
    status[7:0]  = 8'(row);
  end

  // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    rd_val = '0;
    if (!is_ctrl)                rd_val = WB_DATA_WIDTH'(fb_rd);
    else if (loc == '0)          rd_val = WB_DATA_WIDTH'(en);
    else if (loc == PAW'(1))     rd_val = WB_DATA_WIDTH'(div_reg);
    else if (loc == PAW'(2))     rd_val = status;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the framebuffer is reset explicitly so the first scan is dark; it maps to flops, not RAM.
      for (int i = 0; i < NPIX; i++) fb[i] <= '0;
      en         <= 1'b1;
      div_reg    <= DIV_WIDTH'(DIV_RESET);
      o_wb_ack   <= 1'b0;
      o_wb_rdata <= '0;
    end else begin
      o_wb_ack   <= acc;
      o_wb_rdata <= (acc && !i_wb_we) ? rd_val : '0;
      if (acc && i_wb_we) begin
        if (!is_ctrl) begin
          if (pix_ok) fb[loc] <= m_pix[PXW-1:0];
        end else if (loc == '0) begin
          en <= m_ctrl[0];
        end else if (loc == PAW'(1)) begin
          div_reg <= m_div[DIV_WIDTH-1:0];
        end
      end
    end
  end

  // ---------------- Serial clock generator ----------------
  logic [DIV_WIDTH-1:0] div_act, div_cnt;
  logic                 sclk, tick, rise, fall;

  assign tick = (div_cnt == div_act);
  assign rise = tick & ~sclk;
  assign fall = tick & sclk;

  // The new divider is loaded only at a wrap, so a half period is never cut short.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      div_act <= DIV_WIDTH'(DIV_RESET);
      sclk    <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      div_act <= div_reg;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + DIV_WIDTH'(1);
    end
  end

  // ---------------- Scan FSM ----------------
  logic           mosi_n, latch_n, fstart_n;
  logic [PXW-1:0] px;
  logic [BPC-1:0] chan;
  int             px_idx;
`ifdef SEPARATE_COLOR_EN
  logic [1:0]     csel, csel_n;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    grp_n   = grp;
    row_n   = row;
    pwm_n   = pwm;
    blank_n = blank;
`ifdef SEPARATE_COLOR_EN
    csel_n  = csel;
`endif
    unique case (state)
      S_INIT:
        if (cnt == CW'(CHAIN - 1)) begin state_n = S_LATCH; cnt_n = '0; end
        else cnt_n = cnt + CW'(1);
      S_SHIFT_COLOR:
        if (cnt == CW'(COLS - 1)) begin
          cnt_n = '0;
          if (grp == 2'd2) state_n = S_SHIFT_ANODE;
          else             grp_n   = grp + 2'd1;
        end else cnt_n = cnt + CW'(1);
      S_SHIFT_ANODE:
        if (cnt == CW'(ROWS - 1)) begin state_n = S_LATCH; cnt_n = '0; end
        else cnt_n = cnt + CW'(1);
      S_LATCH: state_n = S_PAUSE;
      S_PAUSE:
        if (cnt == CW'(PAUSE_CYCLES - 1)) begin
          cnt_n   = '0;
          grp_n   = '0;
          blank_n = 1'b0;
          state_n = en ? S_SHIFT_COLOR : S_IDLE;
          // The blanking pass after reset does not advance the scan.
          if (!blank) begin
            if (row == RW'(ROWS - 1)) begin
              row_n = '0;
`ifdef SEPARATE_COLOR_EN
              csel_n = (csel == 2'd2) ? 2'd0 : csel + 2'd1;
              if (csel == 2'd2) pwm_n = pwm_step(pwm);
`else
              pwm_n = pwm_step(pwm);
`endif
            end else row_n = row + RW'(1);
          end
        end else cnt_n = cnt + CW'(1);
      S_IDLE:
        if (en) begin state_n = S_SHIFT_COLOR; cnt_n = '0; grp_n = '0; end
      default: state_n = S_INIT;
    endcase
    fstart_n = (state_n == S_SHIFT_COLOR) && (state != S_SHIFT_COLOR) && (row_n == '0);
  end

  // Bit presented on mosi for the step being entered; colours are active-low.
  always_comb begin
    px_idx = int'(row_n) * COLS + int'(cnt_n);
    if (px_idx >= NPIX) px_idx = 0;
    px = fb[px_idx[PAW-1:0]];
    unique case (grp_n)
      2'd0:    chan = px[3*BPC-1 -: BPC];
      2'd1:    chan = px[BPC-1:0];
      default: chan = px[2*BPC-1 -: BPC];
    endcase
    latch_n = (state_n == S_LATCH);
    unique case (state_n)
      S_INIT:        mosi_n = (cnt_n < CW'(3 * COLS));
      S_SHIFT_COLOR: mosi_n = ~(chan > pwm_n);
      S_SHIFT_ANODE: mosi_n = (cnt_n == CW'(row_n));
      S_LATCH:       mosi_n = 1'b0;
      default:       mosi_n = 1'b1;
    endcase
`ifdef SEPARATE_COLOR_EN
    if (state_n == S_SHIFT_COLOR && grp_n != csel_n) mosi_n = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_INIT;
      cnt            <= '0;
      grp            <= '0;
      row            <= '0;
      pwm            <= '0;
      blank          <= 1'b1;
      o_matrix_mosi  <= 1'b1;
      o_matrix_latch <= 1'b0;
      o_matrix_clk   <= 1'b0;
      o_frame_start  <= 1'b0;
`ifdef SEPARATE_COLOR_EN
      csel           <= '0;
`endif
    end else begin
      o_frame_start <= 1'b0;
      if (fall) begin
        state          <= state_n;
        cnt            <= cnt_n;
        grp            <= grp_n;
        row            <= row_n;
        pwm            <= pwm_n;
        blank          <= blank_n;
        o_matrix_mosi  <= mosi_n;
        o_matrix_latch <= latch_n;
        o_matrix_clk   <= 1'b0;
        o_frame_start  <= fstart_n;
`ifdef SEPARATE_COLOR_EN
        csel           <= csel_n;
`endif
      end else if (rise) begin
        o_matrix_clk <= (state == S_INIT) || (state == S_SHIFT_COLOR) || (state == S_SHIFT_ANODE);
      end
    end
  end

endmodule

// File: tb/tb_rgb_matrix_pwm.sv
// Directed testbench for rgb_matrix_pwm (default build, 8x8, BPC=4): chain contents,
// latch/pause timing, PWM threshold, divider change, enable clear and register access.
module tb_rgb_matrix_pwm;
  localparam int AW = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic        cyc, stb, we;
  logic [AW-1:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata, rdata;
  logic        ack, stall, mclk, latch, mosi, fstart;

  int checks = 0;
  int errors = 0;

  rgb_matrix_pwm dut (
    .clk(clk), .reset(reset),
    .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
    .i_wb_sel(sel), .i_wb_wdata(wdata),
    .o_wb_ack(ack), .o_wb_stall(stall), .o_wb_rdata(rdata),
    .o_matrix_clk(mclk), .o_matrix_latch(latch), .o_matrix_mosi(mosi),
    .o_frame_start(fstart)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Chain observer: bit k of sh is the k-th bit shifted since the previous latch.
  logic [31:0] sh = '0, last_word = '0;
  int nbits = 0, last_n = 0, latch_cnt = 0;
  logic mclk_q = 1'b0, latch_q = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      nbits = 0; latch_cnt = 0; sh = '0; mclk_q = 1'b0; latch_q = 1'b0;
    end else begin
      if (mclk && !mclk_q) begin
        if (nbits < 32) sh[nbits] = mosi;
        nbits++;
      end
      if (latch && !latch_q) begin
        last_word = sh; last_n = nbits; nbits = 0; sh = '0; latch_cnt++;
      end
      mclk_q = mclk; latch_q = latch;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input logic [AW-1:0] a, input logic [3:0] s, input logic [31:0] d,
                          input string tag);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; sel = s; wdata = d;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check({tag, " ack"}, 32'(ack), 32'd1);
  endtask

  task automatic wb_read(input logic [AW-1:0] a, output logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a; sel = 4'hF;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    d = ack ? rdata : 32'hDEAD_BEEF;
  endtask

  task automatic wait_latch(input string tag);
    int start;
    bit to;
    start = latch_cnt;
    to = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (latch_cnt != start) begin to = 1'b0; break; end
    end
    check({tag, " latch timeout"}, 32'(to), 32'd0);
  endtask

  task automatic seek_row(input int r, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      wait_latch(tag);
      if (last_word[24 + r]) found = 1'b1;
    end
    check({tag, " row found"}, 32'(found), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    int t, lw, fs_n, fs_at, hw, lo, mc, lc;

    reset = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = '0; sel = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("reset mclk",   32'(mclk),   32'd0);
    check("reset latch",  32'(latch),  32'd0);
    check("reset mosi",   32'(mosi),   32'd1);
    check("reset ack",    32'(ack),    32'd0);
    check("reset rdata",  rdata,       32'd0);
    check("reset fstart", 32'(fstart), 32'd0);
    reset = 1'b0;

    wb_write(7'd65, 4'hF, 32'd0, "div=0");
    wb_write(7'd21, 4'hF, 32'h0000_0F08, "pixel(2,5)");
    wb_read(7'd21, d);  check("read pixel 21", d, 32'h0000_0F08);
    wb_read(7'd22, d);  check("read pixel 22", d, 32'h0);
    wb_read(7'd64, d);  check("read ctrl",     d, 32'h1);
    wb_read(7'd65, d);  check("read div",      d, 32'h0);
    check("stall", 32'(stall), 32'd0);

    // Blanking pass: latch one sclk period (2 clk), 32 pause periods, then row 0 starts.
    t = 0;
    while (!latch && t < 5000) begin @(negedge clk); t++; end
    check("init latch seen", 32'(latch), 32'd1);
    t = 0; lw = 0; fs_n = 0; fs_at = -1;
    while (!mclk && t < 200) begin
      if (latch) lw++;
      if (fstart) begin fs_n++; fs_at = t; end
      @(negedge clk); t++;
    end
    check("init latch width",  32'(lw),    32'd2);
    check("latch to shift",    32'(t),     32'd67);
    check("frame_start count", 32'(fs_n),  32'd1);
    check("frame_start time",  32'(fs_at), 32'd66);
    check("init bit count",    32'(last_n), 32'd32);
    check("init chain",        last_word,  32'h00FF_FFFF);

    wait_latch("row0");
    check("row0 chain", last_word, 32'h01FF_FFFF);

    // Row 2 each frame: red lit always, blue lit only while pwm_cnt < 8, green never.
    for (int f = 0; f < 10; f++) begin
      seek_row(2, "row2");
      check($sformatf("row2 chain f%0d", f), last_word, (f < 8) ? 32'h04FF_DFDF : 32'h04FF_FFDF);
    end
    wb_read(7'd66, d);  check("status row2", d, 32'h0000_0902);

    wb_write(7'd65, 4'hF, 32'd3, "div=3");
    wait_latch("row3");
    check("row3 chain", last_word, 32'h08FF_FFFF);
    t = 0;
    while (!mclk && t < 2000) begin @(negedge clk); t++; end
    hw = 0;
    while (mclk && hw < 100) begin @(negedge clk); hw++; end
    lo = 0;
    while (!mclk && lo < 100) begin @(negedge clk); lo++; end
    check("div3 high", 32'(hw), 32'd4);
    check("div3 period", 32'(hw + lo), 32'd8);

    // Row 4 is now shifting; disable mid-row.
    wb_write(7'd64, 4'b0001, 32'd0, "clear en");
    t = 0;
    while (!latch && t < 2000) begin @(negedge clk); t++; end
    lw = 0;
    while (latch && lw < 100) begin @(negedge clk); lw++; end
    check("div3 latch width", 32'(lw), 32'd8);
    check("row4 chain", last_word, 32'h10FF_FFFF);
    check("row4 bit count", 32'(last_n), 32'd32);
    wb_read(7'd66, d);  check("status row4", d, 32'h0000_0904);
    mc = 0; lc = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (mclk)  mc++;
      if (latch) lc++;
    end
    check("idle no shift", 32'(mc), 32'd0);
    check("idle no latch", 32'(lc), 32'd0);
    check("idle mclk", 32'(mclk), 32'd0);
    check("idle mosi", 32'(mosi), 32'd1);
    wb_read(7'd66, d);  check("status idle", d, 32'h0000_0905);
    wb_read(7'd64, d);  check("ctrl cleared", d, 32'h0);

    wb_write(7'd64, 4'b0001, 32'd1, "set en");
    wait_latch("row5");
    check("row5 chain", last_word, 32'h20FF_FFFF);

    wb_write(7'd0, 4'b0010, 32'h0000_0ABC, "pixel0 byte1");
    wb_read(7'd0, d);   check("pixel0 sel", d, 32'h0000_0A00);
    wb_write(7'd1, 4'hF, 32'hFFFF_FFFF, "pixel1 full");
    wb_read(7'd1, d);   check("pixel1 width", d, 32'h0000_0FFF);
    wb_write(7'd66, 4'hF, 32'hFFFF_FFFF, "status write");
    wb_read(7'd67, d);  check("ctrl3 read", d, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
